// File: rtl/rat_pkg.sv
// rat_pkg: shared types and widths for the rat-maze path playback stage.
package rat_pkg;
  localparam int RAT_COORD_W = 4;
  localparam int RAT_CNT_W = 8;
  typedef enum logic [1:0] {RIGHT = 2'b00, DOWN = 2'b01, LEFT = 2'b10, UP = 2'b11} dir_t;
  typedef enum logic [2:0] {IDLE, POP, LOAD, EMIT, DONE, ERR} play_state_t;
endpackage

// File: rtl/rat_coord_step.sv
// rat_coord_step: applies one direction code to (x, y); wraps modulo 2^W and flags leaving the maze.
module rat_coord_step
  import rat_pkg::*;
#(
  parameter int W = RAT_COORD_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  dir_t         dir,
  output logic [W-1:0] next_x,
  output logic [W-1:0] next_y,
  output logic         oob
);
  always_comb begin
    next_x = dir == RIGHT ? x + 1'b1 : dir == LEFT ? x - 1'b1 : x;
    next_y = dir == DOWN ? y + 1'b1 : dir == UP ? y - 1'b1 : y;
    oob = (dir == RIGHT && &x) || (dir == LEFT && ~|x) || (dir == DOWN && &y) || (dir == UP && ~|y);
  end
endmodule

// File: rtl/rat_path_player.sv
// rat_path_player: drains the reversed-path stack into a valid/ready stream of absolute moves.
// Define RAT_PATH_BOUNDS_CHECK_EN to trap moves leaving the maze instead of wrapping.
module rat_path_player
  import rat_pkg::*;
#(
  parameter int COORD_W = RAT_COORD_W,
  parameter int CNT_W = RAT_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               done_in,
  input  logic               run,
  input  logic [1:0]         stk_dout,
  input  logic               stk_empty,
  output logic               stk_pop,
  output logic               move_valid,
  input  logic               move_ready,
  output logic [1:0]         move_dir,
  output logic [COORD_W-1:0] move_x,
  output logic [COORD_W-1:0] move_y,
  output logic [CNT_W-1:0]   step_count,
  output logic               busy,
  output logic               path_done,
  output logic               err
);
  play_state_t        state_q, state_d;
  dir_t               dir_q, dir_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, nx, ny;
  logic [CNT_W-1:0]   step_q, step_d;
  logic               pop_q, pop_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               oob;

  rat_coord_step #(.W(COORD_W)) u_step (
    .x(x_q), .y(y_q), .dir(dir_t'(stk_dout)), .next_x(nx), .next_y(ny), .oob(oob)
  );

  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    x_d = x_q;
    y_d = y_q;
    step_d = step_q;
    case (state_q)
      IDLE: if (done_in && run) begin
        x_d = '0;
        y_d = '0;
        step_d = '0;
        state_d = stk_empty ? DONE : POP;
      end
      POP: state_d = LOAD;
      LOAD: begin
        dir_d = dir_t'(stk_dout);
        x_d = nx;
        y_d = ny;
        state_d = EMIT;
`ifdef RAT_PATH_BOUNDS_CHECK_EN
        if (oob) begin
          x_d = x_q;
          y_d = y_q;
          state_d = ERR;
        end
`endif
      end
      EMIT: if (move_ready) begin
        step_d = &step_q ? step_q : step_q + 1'b1;
        state_d = stk_empty ? DONE : POP;
      end
      DONE: if (!run) state_d = IDLE;
      default: state_d = state_q;
    endcase
    pop_d = state_d == POP;
    valid_d = state_d == EMIT;
    busy_d = state_d == POP || state_d == LOAD || state_d == EMIT;
    done_d = state_d == DONE;
    err_d = state_d == ERR;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q <= RIGHT;
      x_q <= '0;
      y_q <= '0;
      step_q <= '0;
      pop_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      x_q <= x_d;
      y_q <= y_d;
      step_q <= step_d;
      pop_q <= pop_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end

  assign stk_pop = pop_q;
  assign move_valid = valid_q;
  assign move_dir = dir_q;
  assign move_x = x_q;
  assign move_y = y_q;
  assign step_count = step_q;
  assign busy = busy_q;
  assign path_done = done_q;
`ifdef RAT_PATH_BOUNDS_CHECK_EN
  assign err = err_q;
`else
  logic unused_flags;
  assign unused_flags = oob ^ err_q;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rat_path_player.sv
// tb_rat_path_player: directed checks of rat_path_player against a behavioural stack model.
module tb_rat_path_player;
  logic       clk = 1'b0, rst = 1'b0, done_in = 1'b0, run = 1'b0, move_ready = 1'b1;
  logic [1:0] stk_dout = 2'b00;
  logic       stk_empty, stk_pop, move_valid, busy, path_done, err;
  logic [1:0] move_dir;
  logic [3:0] move_x, move_y;
  logic [7:0] step_count;
  logic [1:0] stk [0:511];
  int         push_cnt = 0, pop_cnt = 0, bad_pop = 0, n_chk = 0, n_fail = 0, pops0;

  rat_path_player dut (
    .clk(clk), .rst(rst), .done_in(done_in), .run(run), .stk_dout(stk_dout),
    .stk_empty(stk_empty), .stk_pop(stk_pop), .move_valid(move_valid), .move_ready(move_ready),
    .move_dir(move_dir), .move_x(move_x), .move_y(move_y), .step_count(step_count),
    .busy(busy), .path_done(path_done), .err(err)
  );

  always #5 clk = ~clk;
  assign stk_empty = push_cnt == pop_cnt;

  // Stack presents the popped entry on the cycle after the pop strobe.
  always @(posedge clk)
    if (stk_pop) begin
      if (push_cnt == pop_cnt) bad_pop <= bad_pop + 1;
      else begin
        stk_dout <= stk[push_cnt - pop_cnt - 1];
        pop_cnt <= pop_cnt + 1;
      end
    end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] v);
    stk[push_cnt - pop_cnt] = v;
    push_cnt++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_pop"}, stk_pop, 0);
    chk({tag, "_valid"}, move_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, path_done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_xy"}, {move_x, move_y}, 0);
    chk({tag, "_dir"}, move_dir, 0);
    chk({tag, "_step"}, step_count, 0);
  endtask

  task automatic wait_valid(input string tag);
    int k = 0;
    while (!move_valid && k < 8) begin
      tick;
      k++;
    end
    chk({tag, "_timeout"}, move_valid, 1);
  endtask

  initial begin
    tick;
    tick;
    chk_idle_outputs("rst");
    rst = 1'b1;
    tick;

    // Three-move path: latency and beat contents
    push(2'b00); push(2'b01); push(2'b00);
    pops0 = pop_cnt;
    done_in = 1'b1;
    run = 1'b1;
    tick;
    chk("t1_pop", stk_pop, 1);
    chk("t1_busy", busy, 1);
    tick;
    chk("t1_pop_once", stk_pop, 0);
    chk("t1_valid_early", move_valid, 0);
    tick;
    chk("t1_valid_lat", move_valid, 1);
    chk("t1_b1", {move_dir, move_x, move_y}, {2'b00, 4'd1, 4'd0});
    chk("t1_step0", step_count, 0);
    tick;
    chk("t1_step1", step_count, 1);
    chk("t1_valid_drop", move_valid, 0);
    wait_valid("t1_b2");
    chk("t1_b2", {move_dir, move_x, move_y}, {2'b01, 4'd1, 4'd1});
    tick;
    wait_valid("t1_b3");
    chk("t1_b3", {move_dir, move_x, move_y}, {2'b00, 4'd2, 4'd1});
    tick;
    chk("t1_done", path_done, 1);
    chk("t1_step3", step_count, 3);
    chk("t1_busy_off", busy, 0);
    chk("t1_pops", pop_cnt - pops0, 3);
    run = 1'b0;
    tick;
    chk("t1_done_drop", path_done, 0);

    // Empty stack at run
    pops0 = pop_cnt;
    run = 1'b1;
    tick;
    chk("t2_done", path_done, 1);
    chk("t2_nopop", stk_pop, 0);
    chk("t2_step", step_count, 0);
    tick;
    chk("t2_pops", pop_cnt - pops0, 0);
    run = 1'b0;
    tick;
    chk("t2_done_drop", path_done, 0);

    // Consumer stall on beat 2; run dropped mid-playback
    push(2'b01); push(2'b00); push(2'b01);
    run = 1'b1;
    wait_valid("t3_b1");
    chk("t3_b1", {move_dir, move_x, move_y}, {2'b01, 4'd0, 4'd1});
    tick;
    run = 1'b0;
    move_ready = 1'b0;
    wait_valid("t3_b2");
    pops0 = pop_cnt;
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold", {move_valid, move_dir, move_x, move_y, step_count}, {1'b1, 2'b00, 4'd1, 4'd1, 8'd1});
      tick;
    end
    chk("t3_hold_pops", pop_cnt - pops0, 0);
    move_ready = 1'b1;
    tick;
    chk("t3_step2", step_count, 2);
    wait_valid("t3_b3");
    chk("t3_b3", {move_dir, move_x, move_y}, {2'b01, 4'd1, 4'd2});
    tick;
    chk("t3_done", {path_done, step_count}, {1'b1, 8'd3});
    tick;
    chk("t3_idle", path_done, 0);

    // Left move from origin
    push(2'b10);
    run = 1'b1;
    tick;
    tick;
    tick;
`ifdef RAT_PATH_BOUNDS_CHECK_EN
    chk("t4_err", err, 1);
    chk("t4_novalid", move_valid, 0);
    tick;
    tick;
    chk("t4_err_hold", {err, move_valid}, {1'b1, 1'b0});
    run = 1'b0;
    rst = 1'b0;
    #2;
    chk("t4_err_rst", err, 0);
    rst = 1'b1;
    tick;
`else
    chk("t4_wrap", {move_valid, move_dir, move_x, move_y}, {1'b1, 2'b10, 4'd15, 4'd0});
    chk("t4_noerr", err, 0);
    tick;
    chk("t4_done", {path_done, step_count}, {1'b1, 8'd1});
    run = 1'b0;
    tick;
`endif

    // Asynchronous reset while a beat is pending
    push(2'b00); push(2'b00);
    move_ready = 1'b0;
    run = 1'b1;
    wait_valid("t5_b1");
    #2 rst = 1'b0;
    #1;
    chk_idle_outputs("t5_async");
    run = 1'b0;
    push_cnt = pop_cnt;
    tick;
    #2 rst = 1'b1;
    tick;
    chk("t5_idle", {busy, path_done, move_valid}, 0);
    push(2'b01);
    move_ready = 1'b1;
    run = 1'b1;
    wait_valid("t5_b2");
    chk("t5_restart", {move_dir, move_x, move_y}, {2'b01, 4'd0, 4'd1});
    tick;
    chk("t5_done", {path_done, step_count}, {1'b1, 8'd1});
    run = 1'b0;
    tick;

    // 300 alternating right/left moves: step counter saturation
    for (int i = 299; i >= 0; i--) push(i % 2 ? 2'b10 : 2'b00);
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      wait_valid("t6_beat");
      chk("t6_x", {move_x, move_y}, {(i % 2 ? 4'd0 : 4'd1), 4'd0});
      tick;
    end
    chk("t6_sat", step_count, 255);
    chk("t6_done", path_done, 1);
    run = 1'b0;
    tick;
    chk("t6_idle", path_done, 0);
    chk("bad_pops", bad_pop, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
